// File: rtl/rng_pkg.sv
// Shared definitions for the die-roll custom instruction: die codes,
// per-die lookup helpers, LFSR constants and the controller state type.
package rng_pkg;

    // Raw sample width and roll width used throughout the block
    localparam int RAND_W = 7;
    localparam int ROLL_W = 5;

    // Die codes carried in dataa[3:0]; anything above DIE_D20 is invalid
    localparam logic [3:0] DIE_D4   = 4'h0;
    localparam logic [3:0] DIE_D6   = 4'h1;
    localparam logic [3:0] DIE_D8   = 4'h2;
    localparam logic [3:0] DIE_D10  = 4'h3;
    localparam logic [3:0] DIE_D12  = 4'h4;
    localparam logic [3:0] DIE_D20  = 4'h5;
    localparam logic [3:0] DIE_NONE = 4'hF;

    // LFSR seed, and the polynomial x^16+x^14+x^13+x^11+1 expressed as the
    // bit positions (0,2,3,5) that feed the new MSB in right-shift form
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_EVAL,
        ST_DONE
    } state_t;

    function automatic logic code_valid(input logic [3:0] code);
        return (code <= DIE_D20);
    endfunction

    // Largest multiple of N that fits in a 7-bit sample; samples at or
    // above it would bias the low faces, so they are thrown away
    function automatic logic [7:0] die_limit(input logic [3:0] code);
        case (code)
            DIE_D4, DIE_D8:           return 8'd128;
            DIE_D6:                   return 8'd126;
            DIE_D10, DIE_D12, DIE_D20: return 8'd120;
            default:                  return 8'd0;
        endcase
    endfunction

    // Number of faces for each die; zero marks an invalid code
    function automatic logic [7:0] die_sides(input logic [3:0] code);
        case (code)
            DIE_D4:  return 8'd4;
            DIE_D6:  return 8'd6;
            DIE_D8:  return 8'd8;
            DIE_D10: return 8'd10;
            DIE_D12: return 8'd12;
            DIE_D20: return 8'd20;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/dice_post_process.sv
// Rejection-sampling post-processor: decides whether a raw sample is
// usable for the selected die and maps it onto the range 1..N.
module dice_post_process #(
    parameter int RAND_W = rng_pkg::RAND_W,
    parameter int ROLL_W = rng_pkg::ROLL_W
) (
    input  logic [3:0]        code,
    input  logic [RAND_W-1:0] sample,
    output logic              accept,
    output logic [ROLL_W-1:0] roll
);
    import rng_pkg::*;

    logic [7:0] limit;
    logic [7:0] sides;
    logic [7:0] remainder;

    // Accept below the die's limit and fold the sample onto 1..N; an
    // invalid code never accepts and yields roll 0
    always_comb begin
        limit     = die_limit(code);
        sides     = die_sides(code);
        accept    = 1'b0;
        roll      = '0;
        remainder = '0;
        if (sides != 8'd0) begin
            remainder = 8'(sample) % sides;
            accept    = (8'(sample) < limit);
            if (accept) begin
                roll = ROLL_W'(remainder + 8'd1);
            end
        end
    end

endmodule

// File: rtl/rng_nios_instr.sv
// Multi-cycle Nios II custom instruction returning a fair die roll built
// from a free-running LFSR, a serial collector and rejection sampling.
module rng_nios_instr #(
    parameter int RAND_W = rng_pkg::RAND_W,
    parameter int ROLL_W = rng_pkg::ROLL_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done
);
    import rng_pkg::*;

    state_t             state;
    logic [15:0]        lfsr;
    logic [RAND_W-1:0]  collector;
    logic [2:0]         bit_count;
    logic [3:0]         code_latched;
    logic [ROLL_W-1:0]  roll_reg;
    logic               pp_accept;
    logic [ROLL_W-1:0]  pp_roll;

    // Only the die code field of dataa carries meaning; the rest is dropped
    logic unused_inputs;
    assign unused_inputs = ^{datab, dataa[31:4]};

    dice_post_process #(
        .RAND_W (RAND_W),
        .ROLL_W (ROLL_W)
    ) u_post (
        .code   (code_latched),
        .sample (collector),
        .accept (pp_accept),
        .roll   (pp_roll)
    );

    // Entropy source keeps running in every state so idle time adds mixing
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (clk_en) begin
            lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
        end
    end

    // Controller: latch request, collect 7 bits, evaluate, report with a done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            collector    <= '0;
            bit_count    <= '0;
            code_latched <= '0;
            roll_reg     <= '0;
            done         <= 1'b0;
            result       <= '0;
        end else if (clk_en) begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        code_latched <= dataa[3:0];
                        if (code_valid(dataa[3:0])) begin
                            bit_count <= '0;
                            state     <= ST_COLLECT;
                        end else begin
                            roll_reg <= '0;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_COLLECT: begin
                    collector <= {collector[RAND_W-2:0], lfsr[0]};
                    bit_count <= bit_count + 3'd1;
                    if (bit_count == 3'(RAND_W - 1)) begin
                        state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (pp_accept) begin
                        roll_reg <= pp_roll;
                        state    <= ST_DONE;
                    end else begin
                        bit_count <= '0;
                        state     <= ST_COLLECT;
                    end
                end
                ST_DONE: begin
                    done   <= 1'b1;
                    result <= {{(32 - ROLL_W){1'b0}}, roll_reg};
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_nios_instr.sv
// Self-checking bench for rng_nios_instr: table vectors for the
// post-processor, plus scoreboarded roll sequences against a reference model.
`timescale 1ns/1ps
module tb_rng_nios_instr;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;

    logic [3:0]  pp_code;
    logic [6:0]  pp_sample;
    logic        pp_accept;
    logic [4:0]  pp_roll;

    int compared   = 0;
    int mismatched = 0;
    int timeouts   = 0;
    bit aborted    = 1'b0;

    typedef struct packed {
        logic [31:0] roll;
        logic [31:0] latency;
    } exp_t;

    typedef struct packed {
        logic [3:0] code;
        logic [6:0] sample;
        logic       accept;
        logic [4:0] roll;
    } vec_t;

    exp_t sbQ[$];
    vec_t vecs[14];
    logic [15:0] refLfsr;

    always #5 clk = ~clk;

    rng_nios_instr dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .dataa  (dataa),
        .datab  (datab),
        .result (result),
        .done   (done)
    );

    dice_post_process u_pp (
        .code   (pp_code),
        .sample (pp_sample),
        .accept (pp_accept),
        .roll   (pp_roll)
    );

    function automatic logic [15:0] lfsrStep(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Reference entropy source, reseeded and frozen exactly like the spec says
    always @(posedge clk) begin
        if (reset) refLfsr <= 16'hACE1;
        else if (clk_en) refLfsr <= lfsrStep(refLfsr);
    end

    function automatic int tbSides(input logic [3:0] c);
        case (c)
            4'h0: return 4;
            4'h1: return 6;
            4'h2: return 8;
            4'h3: return 10;
            4'h4: return 12;
            4'h5: return 20;
            default: return 0;
        endcase
    endfunction

    // Predict roll and done latency from the LFSR value seen at the start edge
    function automatic exp_t predict(input logic [15:0] l0, input logic [3:0] code);
        exp_t e;
        logic [15:0] l;
        int s;
        int limit;
        int sample;
        s = tbSides(code);
        e.roll = 0;
        e.latency = 1;
        if (s == 0) return e;
        limit = (128 / s) * s;
        l = l0;
        e.latency = 9;
        for (int attempt = 0; attempt < 1000; attempt++) begin
            sample = 0;
            for (int b = 0; b < 7; b++) begin
                l = lfsrStep(l);
                sample = sample * 2 + int'(l[0]);
            end
            if (sample < limit) begin
                e.roll = 32'(sample % s + 1);
                return e;
            end
            l = lfsrStep(l);
            e.latency = e.latency + 8;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Called at a falling edge while the DUT is idle: drive a request and
    // record what it should produce
    task automatic applyStimulus(input logic [3:0] code);
        start = 1'b1;
        dataa = {28'($urandom()), code};
        datab = $urandom();
        sbQ.push_back(predict(refLfsr, code));
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset  = 1'b1;
        start  = 1'b0;
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_result", result, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // One operation; optional clk_en freeze, dataa change or reset at cycle n
    task automatic runOp(input string tag, input logic [3:0] code, input bit holdStart,
                         input int freezeAt, input int changeAt, input logic [3:0] newCode,
                         input int resetAt, output int gotRoll, output int gotLat);
        exp_t e;
        int n;
        bit seen;
        gotRoll = -1;
        gotLat  = -1;
        if (aborted) return;
        applyStimulus(code);
        @(posedge clk);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!holdStart) start = 1'b0;
            if (n == freezeAt) clk_en = 1'b0;
            if (freezeAt > 0 && n == freezeAt + 5) clk_en = 1'b1;
            if (n == changeAt) dataa[3:0] = newCode;
            if (n == resetAt) reset = 1'b1;
            if (done === 1'b1) seen = 1'b1;
            if (resetAt > 0 && n == resetAt + 1) begin
                checkOutput({tag, "_reset_done"}, 32'(done), 32'd0);
                checkOutput({tag, "_reset_result"}, result, 32'd0);
                reset = 1'b0;
                break;
            end
        end
        e = sbQ.pop_front();
        if (resetAt > 0) begin
            checkOutput({tag, "_done_before_reset"}, 32'(seen), 32'd0);
        end else if (!seen) begin
            compared++;
            mismatched++;
            timeouts++;
            $display("[TB] FAIL %s_timeout: no done within %0d cycles, expected latency %0d",
                     tag, n, e.latency);
            if (timeouts >= 3) aborted = 1'b1;
        end else begin
            gotRoll = int'(result[4:0]);
            gotLat  = n;
            checkOutput({tag, "_latency"}, 32'(n), e.latency + ((freezeAt > 0) ? 32'd5 : 32'd0));
            checkOutput({tag, "_roll"}, result, e.roll);
            checkOutput({tag, "_upper_zero"}, 32'(result[31:5]), 32'd0);
        end
    endtask

    initial begin
        int r;
        int l;
        int refRoll;
        int refLat;
        int rA;
        int faces[21];

        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        dataa  = '0;
        datab  = '0;
        pp_code   = '0;
        pp_sample = '0;

        // Post-processor vectors: {code, sample, accept, roll}
        vecs[0]  = '{4'h1, 7'd125, 1'b1, 5'd6};
        vecs[1]  = '{4'h1, 7'd126, 1'b0, 5'd0};
        vecs[2]  = '{4'h5, 7'd119, 1'b1, 5'd20};
        vecs[3]  = '{4'h5, 7'd120, 1'b0, 5'd0};
        vecs[4]  = '{4'h0, 7'd0,   1'b1, 5'd1};
        vecs[5]  = '{4'h0, 7'd127, 1'b1, 5'd4};
        vecs[6]  = '{4'h2, 7'd127, 1'b1, 5'd8};
        vecs[7]  = '{4'h2, 7'd0,   1'b1, 5'd1};
        vecs[8]  = '{4'h3, 7'd119, 1'b1, 5'd10};
        vecs[9]  = '{4'h3, 7'd120, 1'b0, 5'd0};
        vecs[10] = '{4'h4, 7'd119, 1'b1, 5'd12};
        vecs[11] = '{4'h4, 7'd64,  1'b1, 5'd5};
        vecs[12] = '{4'h1, 7'd0,   1'b1, 5'd1};
        vecs[13] = '{4'h5, 7'd37,  1'b1, 5'd18};

        for (int i = 0; i < 14; i++) begin
            pp_code   = vecs[i].code;
            pp_sample = vecs[i].sample;
            #1;
            checkOutput($sformatf("pp_accept_%0d", i), 32'(pp_accept), 32'(vecs[i].accept));
            if (vecs[i].accept) begin
                checkOutput($sformatf("pp_roll_%0d", i), 32'(pp_roll), 32'(vecs[i].roll));
            end
        end

        // First D20 request after reset; remembered as the post-reset reference
        resetDut();
        runOp("first_d20", 4'h5, 1'b0, 0, 0, 4'h0, 0, refRoll, refLat);

        // Invalid code with start held: done every second cycle, result 0
        for (int i = 0; i < 6; i++) begin
            runOp("invalid_held", 4'hF, 1'b1, 0, 0, 4'h0, 0, r, l);
        end

        // 1000 D20 then 1000 D6 rolls back to back with start held
        for (int f = 0; f < 21; f++) faces[f] = 0;
        for (int i = 0; i < 1000 && !aborted; i++) begin
            runOp("d20_held", 4'h5, 1'b1, 0, 0, 4'h0, 0, r, l);
            checkOutput("d20_range", 32'(r >= 1 && r <= 20), 32'd1);
            if (r >= 1 && r <= 20) faces[r]++;
        end
        for (int f = 1; f <= 20; f++) begin
            checkOutput($sformatf("d20_face_%0d_seen", f), 32'(faces[f] > 0), 32'd1);
        end
        for (int f = 0; f < 21; f++) faces[f] = 0;
        for (int i = 0; i < 1000 && !aborted; i++) begin
            runOp("d6_held", 4'h1, 1'b1, 0, 0, 4'h0, 0, r, l);
            checkOutput("d6_range", 32'(r >= 1 && r <= 6), 32'd1);
            if (r >= 1 && r <= 6) faces[r]++;
        end
        for (int f = 1; f <= 6; f++) begin
            checkOutput($sformatf("d6_face_%0d_seen", f), 32'(faces[f] > 0), 32'd1);
        end
        start = 1'b0;

        // clk_en dropped for 5 cycles mid-COLLECT: same roll, 5 cycles later
        resetDut();
        runOp("undelayed", 4'h5, 1'b0, 0, 0, 4'h0, 0, rA, l);
        resetDut();
        runOp("frozen", 4'h5, 1'b0, 3, 0, 4'h0, 0, r, l);
        checkOutput("freeze_same_roll", 32'(r), 32'(rA));

        // dataa switched to D6 during COLLECT: latched D20 code still applies
        runOp("dataa_change", 4'h5, 1'b0, 0, 3, 4'h1, 0, r, l);
        checkOutput("dataa_change_range", 32'(r >= 1 && r <= 20), 32'd1);

        // Reset during EVAL: no done, then behaves exactly like a fresh start
        runOp("reset_eval", 4'h5, 1'b0, 0, 0, 4'h0, 7, r, l);
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_eval_idle_done", 32'(done), 32'd0);
        end
        runOp("after_reset", 4'h5, 1'b0, 0, 0, 4'h0, 0, r, l);
        checkOutput("after_reset_roll_vs_first", 32'(r), 32'(refRoll));
        checkOutput("after_reset_lat_vs_first", 32'(l), 32'(refLat));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
